alk_rot_issue: RTL and testbench
================================

// Module: alk_rot_issue
// PURPOSE
//  ROT micro-op field issue stage: buffers 6-bit ROT codes from microword fetch, drives registered rot_h to the ALK.
//  Producer end of the ROT field: enforces S/P-latch interlock by inserting NOP bubbles between S/P-modifying ROTs.
//  S/P-modifying set (MODSP): ROT = 27,2D,2F,3B,3D,3F (hex); identical to the ALK's modsp decode.
// PARAMETERS
//  DEPTH   4      ROT FIFO entries (power of two, >=2)
//  SP_GAP  1      min non-stalled cycles between issue of two MODSP ROTs (0 = no interlock)
// PORTS
//  clk_h        in   1  clock, all state on rising edge
//  reset_h      in   1  synchronous reset, active-high
//  in_rot_h     in   6  ROT code from microword fetch
//  in_valid_h   in   1  in_rot_h valid
//  in_ready_h   out  1  FIFO can accept (count != DEPTH); transfer when valid & ready
//  stall_h      in   1  DPM pipeline stall: hold all outputs and state except FIFO push
//  rot_h        out  6  ROT field to ALK (registered)
//  rot_valid_h  out  1  rot_h carries a real op (0 = NOP/bubble)
//  modsp_h      out  1  registered: issued rot_h is in MODSP
//  count_h      out  $clog2(DEPTH)+1  FIFO occupancy
//  rot_par_h    out  1  (ALK_ROT_PARITY_EN only) odd parity over rot_h
// BEHAVIOUR
//  Reset (sync, wins over everything): rot_h=ROT_NOP(6'h00), rot_valid_h=0, modsp_h=0, count=0, gap=0,
//   FIFO flushed (pending entries discarded mid-operation), state=RUN; rot_par_h=1.
//  FIFO: push on in_valid_h&in_ready_h; pop only on issue; push+pop same cycle allowed (count unchanged).
//   No bypass: entry pushed at edge E issues at earliest edge E+1 (visible on rot_h after E+1).
//   in_ready_h is combinational from count only; never depends on in_valid_h or stall_h.
//  Issue, evaluated each edge with stall_h=0 (head = FIFO head):
//   - FIFO empty: rot_h<=ROT_NOP, rot_valid_h<=0, modsp_h<=0.
//   - head MODSP and gap!=0: bubble (NOP, valid 0), no pop, gap<=gap-1.
//   - else: pop, rot_h<=head, rot_valid_h<=1, modsp_h<=is_modsp(head);
//     gap<=SP_GAP if head MODSP, else gap<=sat_dec(gap).
//   - gap decrements (saturating at 0) on every non-stalled cycle, so intervening non-MODSP ops count toward gap.
//  stall_h=1: rot_h/rot_valid_h/modsp_h/gap/state hold; no pop; push still permitted.
//  FSM: RUN (gap==0) <-> GAP (gap!=0). RUN->GAP on issuing MODSP with SP_GAP>0; GAP->RUN when gap reaches 0.
//  Full+push attempt: in_ready_h=0, in_rot_h ignored. Empty+stall: NOP held. Pointers wrap modulo DEPTH.
// CONFIGURATION
//  `define ALK_ROT_PARITY_EN: adds rot_par_h, registered with rot_h, = ~^rot_h (odd parity; NOP -> 1), holds on stall.
//  Without it: port absent, no parity logic.
// STRUCTURE
//  Package alk_rot_pkg: ROT_W=6, ROT_NOP=6'h00, function is_modsp(rot) (MODSP set above), state enum {RUN,GAP}.
//  Sub-module alk_rot_fifo: DEPTH-entry sync FIFO (push/pop/count/head, sync reset); issue FSM in top.
// TESTING
//  1 Reset: hold reset_h 2 cycles with in_valid_h=1 -> rot_h=00, rot_valid_h=0, count=0, in_ready_h=1.
//  2 Latency: push 14 at edge E into empty FIFO -> rot_h=14, rot_valid_h=1, modsp_h=0 after E+1; then NOP.
//  3 Interlock SP_GAP=1: push 27,3D back-to-back -> rot_h 27(modsp=1), 00(valid=0), 3D(modsp=1);
//    push 27,14,3D -> 27,14,3D with no bubble.
//  4 Full/wrap: stall_h=1, push 5 ops into DEPTH=4 -> 4 accepted, in_ready_h=0 on 5th, count=4;
//    release stall -> 4 ops issue in order, pointers wrap, count back to 0; repeat twice.
//  5 Stall mid-gap: issue 2F, assert stall_h 3 cycles with 3B queued -> rot_h holds 2F;
//    after release one bubble then 3B.
//  6 Reset mid-operation: 3 entries queued, reset_h 1 cycle -> count=0, rot_h=00, queued ops never issue;
//    with ALK_ROT_PARITY_EN check rot_par_h=~^rot_h every cycle (3F -> 1, 27 -> 1, 2D -> 1, 14 -> 1).

Source files
------------

// File: rtl/alk_rot_pkg.sv
// Shared ROT-field definitions: code width, NOP encoding, MODSP decode and issue FSM states.
package alk_rot_pkg;

  localparam int ROT_W = 6;
  localparam logic [ROT_W-1:0] ROT_NOP = 6'h00;

  typedef enum logic [0:0] {
    RUN = 1'b0,
    GAP = 1'b1
  } rot_state_e;

  // Must stay identical to the ALK's modsp decode, or the interlock is meaningless.
  function automatic logic is_modsp(input logic [ROT_W-1:0] rot);
    case (rot)
      6'h27, 6'h2D, 6'h2F, 6'h3B, 6'h3D, 6'h3F: is_modsp = 1'b1;
      default:                                  is_modsp = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alk_rot_issue_if.sv
// Microword-fetch to ROT-issue handshake: ROT code with valid/ready transfer.
interface alk_rot_issue_if;
  import alk_rot_pkg::*;

  logic [ROT_W-1:0] in_rot_h;
  logic             in_valid_h;
  logic             in_ready_h;

  modport master (output in_rot_h, output in_valid_h, input in_ready_h);
  modport slave  (input in_rot_h, input in_valid_h, output in_ready_h);

endinterface

// File: rtl/alk_rot_fifo.sv
// DEPTH-entry synchronous FIFO for pending ROT codes; caller guarantees no push when full, no pop when empty.
module alk_rot_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic                   clk_h,
  input  logic                   reset_h,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [W-1:0]           i_din,
  output logic [W-1:0]           o_head,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  // NOTE: storage is left out of reset; only pointers and count decide what is valid,
  // so a flush is just clearing them and the array maps to plain RAM/flops without reset.
  always_ff @(posedge clk_h) begin
    if (i_push) r_mem[r_wr_ptr] <= i_din;
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_h) begin
    if (reset_h) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/alk_rot_issue.sv
// ROT issue stage: FIFO-buffers ROT codes and drives registered rot_h, inserting bubbles between MODSP ROTs.
// Optional `ALK_ROT_PARITY_EN adds the registered odd-parity output rot_par_h.
module alk_rot_issue
  import alk_rot_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int SP_GAP = 1
) (
  input  logic                   clk_h,
  input  logic                   reset_h,
  alk_rot_issue_if.slave         in_if,
  input  logic                   stall_h,
  output logic [ROT_W-1:0]       rot_h,
  output logic                   rot_valid_h,
  output logic                   modsp_h,
  output logic [$clog2(DEPTH):0] count_h
`ifdef ALK_ROT_PARITY_EN
  ,
  output logic                   rot_par_h
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int GW = (SP_GAP > 0) ? $clog2(SP_GAP + 1) : 1;
  localparam logic [0:0] S_RUN = RUN;
  localparam logic [0:0] S_GAP = GAP;

  logic [ROT_W-1:0] r_rot;
  logic             r_valid;
  logic             r_modsp;
  logic [GW-1:0]    r_gap;
  logic [0:0]       r_state;

  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_head_modsp;
  logic [ROT_W-1:0] w_head;
  logic [CW-1:0]    w_count;
  logic [GW-1:0]    w_gap_nxt;
  logic [ROT_W-1:0] w_rot_nxt;

  alk_rot_fifo #(.DEPTH(DEPTH), .W(ROT_W)) u_fifo (
    .clk_h   (clk_h),
    .reset_h (reset_h),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (in_if.in_rot_h),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign in_if.in_ready_h = (w_count != CW'(DEPTH));
  assign w_push           = in_if.in_valid_h & in_if.in_ready_h;
  assign w_head_modsp     = is_modsp(w_head);

  // GAP state means the previous MODSP is still too close: a MODSP head must wait.
  assign w_pop = !stall_h && !w_empty && !(w_head_modsp && (r_state == S_GAP));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_rot_nxt = ROT_NOP;
    w_gap_nxt = (r_gap != '0) ? r_gap - GW'(1) : '0;
    if (w_pop) begin
      w_rot_nxt = w_head;
      if (w_head_modsp) w_gap_nxt = GW'(SP_GAP);
    end
  end

  always_ff @(posedge clk_h) begin
    if (reset_h) begin
      r_rot   <= ROT_NOP;
      r_valid <= 1'b0;
      r_modsp <= 1'b0;
      r_gap   <= '0;
      r_state <= S_RUN;
    end else if (!stall_h) begin
      r_rot   <= w_rot_nxt;
      r_valid <= w_pop;
      r_modsp <= w_pop & w_head_modsp;
      r_gap   <= w_gap_nxt;
      r_state <= (w_gap_nxt != '0) ? S_GAP : S_RUN;
    end
  end

`ifdef ALK_ROT_PARITY_EN
  logic r_par;

  always_ff @(posedge clk_h) begin
    if (reset_h)       r_par <= 1'b1;
    else if (!stall_h) r_par <= ~^w_rot_nxt;
  end

  assign rot_par_h = r_par;
`endif

  assign rot_h       = r_rot;
  assign rot_valid_h = r_valid;
  assign modsp_h     = r_modsp;
  assign count_h     = w_count;

endmodule

// File: tb/tb_alk_rot_issue.sv
// Directed and randomized checks of alk_rot_issue against a queue-based reference model.
module tb_alk_rot_issue;
  import alk_rot_pkg::*;

  localparam int DEPTH  = 4;
  localparam int SP_GAP = 1;

  logic       clk_h = 1'b0;
  logic       reset_h;
  logic       stall_h;
  logic [5:0] rot_h;
  logic       rot_valid_h;
  logic       modsp_h;
  logic [2:0] count_h;
`ifdef ALK_ROT_PARITY_EN
  logic       rot_par_h;
`endif

  alk_rot_issue_if bus ();

  alk_rot_issue #(.DEPTH(DEPTH), .SP_GAP(SP_GAP)) dut (
    .clk_h       (clk_h),
    .reset_h     (reset_h),
    .in_if       (bus),
    .stall_h     (stall_h),
    .rot_h       (rot_h),
    .rot_valid_h (rot_valid_h),
    .modsp_h     (modsp_h),
    .count_h     (count_h)
`ifdef ALK_ROT_PARITY_EN
    ,
    .rot_par_h   (rot_par_h)
`endif
  );

  always #5 clk_h = ~clk_h;

  int n_checks = 0;
  int n_err    = 0;
  bit started  = 0;

  // Reference model: pending ops as a queue, gap as a plain integer countdown.
  int unsigned q[$];
  int          gap;
  logic [5:0]  m_rot;
  bit          m_valid;
  bit          m_modsp;

  function automatic bit ref_modsp(input int unsigned v);
    return v inside {'h27, 'h2D, 'h2F, 'h3B, 'h3D, 'h3F};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit r, input bit v, input logic [5:0] d, input bit s);
    reset_h        = r;
    bus.in_valid_h = v;
    bus.in_rot_h   = d;
    stall_h        = s;
  endtask

  task automatic model_step();
    bit can_push;
    if (reset_h) begin
      q.delete();
      gap = 0; m_rot = 6'h00; m_valid = 0; m_modsp = 0;
      return;
    end
    can_push = bus.in_valid_h && (q.size() < DEPTH);
    if (!stall_h) begin
      if (q.size() == 0) begin
        m_rot = 6'h00; m_valid = 0; m_modsp = 0;
        gap = (gap > 0) ? gap - 1 : 0;
      end else if (ref_modsp(q[0]) && gap > 0) begin
        m_rot = 6'h00; m_valid = 0; m_modsp = 0;
        gap = gap - 1;
      end else begin
        m_rot   = 6'(q.pop_front());
        m_valid = 1;
        m_modsp = ref_modsp(m_rot);
        gap     = m_modsp ? SP_GAP : ((gap > 0) ? gap - 1 : 0);
      end
    end
    if (can_push) q.push_back(bus.in_rot_h);
  endtask

  task automatic tick();
    if (started) check("in_ready", bus.in_ready_h, (q.size() < DEPTH));
    @(posedge clk_h);
    model_step();
    #1;
    started = 1;
    check("rot", rot_h, m_rot);
    check("rot_valid", rot_valid_h, m_valid);
    check("modsp", modsp_h, m_modsp);
    check("count", count_h, q.size());
`ifdef ALK_ROT_PARITY_EN
    check("rot_par", rot_par_h, ~^m_rot);
`endif
  endtask

  logic [5:0] modsp_tab [6];

  initial begin
    modsp_tab[0] = 6'h27; modsp_tab[1] = 6'h2D; modsp_tab[2] = 6'h2F;
    modsp_tab[3] = 6'h3B; modsp_tab[4] = 6'h3D; modsp_tab[5] = 6'h3F;

    // 1: reset held two cycles with valid asserted
    drive(1, 1, 6'h14, 0);
    tick(); tick();
    check("t1_rot", rot_h, 6'h00);
    check("t1_valid", rot_valid_h, 1'b0);
    check("t1_count", count_h, 3'd0);
    check("t1_ready", bus.in_ready_h, 1'b1);

    // 2: single-op latency
    drive(0, 1, 6'h14, 0); tick();
    check("t2_e_rot", rot_h, 6'h00);
    drive(0, 0, 6'h00, 0); tick();
    check("t2_rot", rot_h, 6'h14);
    check("t2_valid", rot_valid_h, 1'b1);
    check("t2_modsp", modsp_h, 1'b0);
    tick();
    check("t2_nop", rot_valid_h, 1'b0);

    // 3: interlock, back-to-back MODSP then separated by a plain op
    drive(0, 1, 6'h27, 0); tick();
    drive(0, 1, 6'h3D, 0); tick();
    check("t3a_27", rot_h, 6'h27);
    check("t3a_27m", modsp_h, 1'b1);
    drive(0, 0, 6'h00, 0); tick();
    check("t3a_bubble", rot_valid_h, 1'b0);
    tick();
    check("t3a_3d", rot_h, 6'h3D);
    check("t3a_3dm", modsp_h, 1'b1);
    tick(); tick();
    drive(0, 1, 6'h27, 0); tick();
    drive(0, 1, 6'h14, 0); tick();
    check("t3b_27", rot_h, 6'h27);
    drive(0, 1, 6'h3D, 0); tick();
    check("t3b_14", rot_h, 6'h14);
    drive(0, 0, 6'h00, 0); tick();
    check("t3b_3d", rot_h, 6'h3D);
    check("t3b_3dv", rot_valid_h, 1'b1);
    tick();

    // 4: fill under stall, overflow attempt, drain with wrap, three rounds
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 5; k++) begin
        drive(0, 1, 6'(8 * r + k + 1), 1);
        if (k == 4) check("t4_full_ready", bus.in_ready_h, 1'b0);
        tick();
      end
      check("t4_count", count_h, 3'd4);
      for (int k = 0; k < 4; k++) begin
        drive(0, 0, 6'h00, 0); tick();
        check("t4_order", rot_h, 6'(8 * r + k + 1));
      end
      check("t4_empty", count_h, 3'd0);
    end

    // 5: stall while the gap is pending
    drive(0, 1, 6'h2F, 0); tick();
    drive(0, 1, 6'h3B, 0); tick();
    check("t5_2f", rot_h, 6'h2F);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 6'h00, 1); tick();
      check("t5_hold", rot_h, 6'h2F);
    end
    drive(0, 0, 6'h00, 0); tick();
    check("t5_bubble", rot_valid_h, 1'b0);
    tick();
    check("t5_3b", rot_h, 6'h3B);

    // 6: reset with entries queued
    drive(0, 1, 6'h3F, 1); tick();
    drive(0, 1, 6'h27, 1); tick();
    drive(0, 1, 6'h2D, 1); tick();
    check("t6_queued", count_h, 3'd3);
    drive(1, 0, 6'h00, 0); tick();
    check("t6_count", count_h, 3'd0);
    drive(0, 0, 6'h00, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t6_noissue", rot_valid_h, 1'b0);
    end

    // Randomized traffic, biased toward MODSP codes
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 1) != 0) ? modsp_tab[$urandom_range(0, 5)] : 6'($urandom_range(0, 63)),
            ($urandom_range(0, 3) == 0));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
